// File: rtl/au_pkg.sv
// Shared types for the AU_32b issue controller: opcodes, issue FSM states, default width.
package au_pkg;

  localparam int AU_WIDTH = 32;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_MULT = 2'b10,
    ALU_DIV  = 2'b11
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    WAIT   = 2'b10,
    RESP   = 2'b11
  } issue_state_t;

endpackage

// File: rtl/au_wait_counter.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module au_wait_counter
  import au_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/au_issue_ctrl.sv
// Issues one request at a time to AU_32b, waits out its latency and returns the captured results.
// Optional `define AU_DIV0_TRAP_EN answers DIV by zero locally with rsp_err=1 instead of using the AU.
module au_issue_ctrl
  import au_pkg::*;
#(
  parameter int WIDTH         = AU_WIDTH,
  parameter int ADDSUB_CYCLES = 1,
  parameter int MULDIV_CYCLES = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_op,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic [1:0]       au_aluop,
  output logic             au_start,
  input  logic [WIDTH-1:0] au_s,
  input  logic [WIDTH-1:0] au_hi,
  input  logic [WIDTH-1:0] au_lo,
  input  logic             au_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             rsp_zero,
  output logic             rsp_err
);

  localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] ADDSUB_LOAD = CNT_W'(ADDSUB_CYCLES - 1);
  localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  issue_state_t     state;
  aluop_t           op_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_done;

  // Handshake and launch strobes decode straight from state, so reset clears them immediately.
  assign req_ready = (state == IDLE);
  assign au_start  = (state == LAUNCH);
  assign rsp_valid = (state == RESP);
  assign au_aluop  = op_q;

  assign cnt_load     = (state == LAUNCH);
  assign cnt_load_val = ((op_q == ALU_MULT) || (op_q == ALU_DIV)) ? MULDIV_LOAD : ADDSUB_LOAD;

  au_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .done     (cnt_done)
  );

`ifdef AU_DIV0_TRAP_EN
  logic rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= ALU_ADD;
      au_a     <= '0;
      au_b     <= '0;
      rsp_s    <= '0;
      rsp_hi   <= '0;
      rsp_lo   <= '0;
      rsp_zero <= 1'b0;
`ifdef AU_DIV0_TRAP_EN
      rsp_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            au_a <= req_a;
            au_b <= req_b;
            op_q <= aluop_t'(req_op);
`ifdef AU_DIV0_TRAP_EN
            // Divide by zero is answered here without involving the AU.
            if ((aluop_t'(req_op) == ALU_DIV) && (req_b == '0)) begin
              rsp_s     <= '0;
              rsp_hi    <= '0;
              rsp_lo    <= '0;
              rsp_zero  <= 1'b1;
              rsp_err_q <= 1'b1;
              state     <= RESP;
            end else begin
              state <= LAUNCH;
            end
`else
            state <= LAUNCH;
`endif
          end
        end
        LAUNCH: state <= WAIT;
        WAIT: begin
          if (cnt_done) begin
            rsp_s    <= au_s;
            rsp_hi   <= au_hi;
            rsp_lo   <= au_lo;
            rsp_zero <= au_zero;
`ifdef AU_DIV0_TRAP_EN
            rsp_err_q <= 1'b0;
`endif
            state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_au_issue_ctrl.sv
// Directed bench for au_issue_ctrl with a behavioural AU_32b model (1-cycle add/sub, 33-cycle mul/div).
module tb_au_issue_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] au_a, au_b;
  logic [1:0]   au_aluop;
  logic         au_start;
  logic [W-1:0] au_s = '0;
  logic [W-1:0] au_hi = '0;
  logic [W-1:0] au_lo = '0;
  logic         au_zero = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_s, rsp_hi, rsp_lo;
  logic         rsp_zero, rsp_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  au_issue_ctrl #(.WIDTH(W), .ADDSUB_CYCLES(1), .MULDIV_CYCLES(33)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .au_a(au_a), .au_b(au_b), .au_aluop(au_aluop), .au_start(au_start),
    .au_s(au_s), .au_hi(au_hi), .au_lo(au_lo), .au_zero(au_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // AU model: s/zero valid one cycle after start, hi/lo garbage until 33 cycles after start.
  logic [W-1:0] a_l = '0, b_l = '0;
  logic [1:0]   op_l = 2'b00;
  int           md_cnt = 0;

  always @(posedge clk) begin
    logic [W-1:0] t;
    logic [63:0]  p;
    if (au_start) begin
      a_l  <= au_a;
      b_l  <= au_b;
      op_l <= au_aluop;
      au_hi <= 32'hDEAD_BEEF;
      au_lo <= 32'hDEAD_BEEF;
      if (au_aluop == 2'b00) begin
        t = au_a + au_b;
        au_s <= t;
        au_zero <= (t == '0);
        md_cnt <= 0;
      end else if (au_aluop == 2'b01) begin
        t = au_a - au_b;
        au_s <= t;
        au_zero <= (t == '0);
        md_cnt <= 0;
      end else begin
        md_cnt <= 32;
      end
    end else if (md_cnt != 0) begin
      md_cnt <= md_cnt - 1;
      if (md_cnt == 1) begin
        if (op_l == 2'b10) begin
          p = {32'd0, a_l} * {32'd0, b_l};
          au_hi <= p[63:32];
          au_lo <= p[31:0];
          au_zero <= (p == 64'd0);
        end else if (b_l == '0) begin
          au_hi <= a_l;
          au_lo <= 32'hFFFF_FFFF;
          au_zero <= 1'b0;
        end else begin
          au_hi <= a_l % b_l;
          au_lo <= a_l / b_l;
          au_zero <= ((a_l / b_l) == '0);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept one request, then advance until rsp_valid; lat counts cycles from the accept cycle (0).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        output int lat, output int starts, output int rdy_seen);
    req_a = a;
    req_b = b;
    req_op = op;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    starts = 0;
    rdy_seen = 0;
    while (!rsp_valid && lat < 200) begin
      if (au_start) starts++;
      if (req_ready) rdy_seen++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  int lat, starts, rdy;
  int bad;
  logic seen;

  initial begin
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_au_start", au_start, 0);
    chk("rst_au_a", au_a, 0);
    chk("rst_rsp_s", rsp_s, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with rsp_ready already high while waiting
    rsp_ready = 1'b1;
    run_op(32'd5, 32'd7, 2'b00, lat, starts, rdy);
    chk("add_lat", lat, 3);
    chk("add_starts", starts, 1);
    chk("add_s", rsp_s, 12);
    chk("add_zero", rsp_zero, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("add_valid_drop", rsp_valid, 0);
    chk("add_ready_back", req_ready, 1);

    // SUB to zero
    run_op(32'd9, 32'd9, 2'b01, lat, starts, rdy);
    chk("sub_lat", lat, 3);
    chk("sub_ready_low", rdy, 0);
    chk("sub_ready_resp", req_ready, 0);
    chk("sub_s", rsp_s, 0);
    chk("sub_zero", rsp_zero, 1);
    take_rsp();
    chk("sub_ready_back", req_ready, 1);

    // MULT 2^16 * 2^16
    run_op(32'h0001_0000, 32'h0001_0000, 2'b10, lat, starts, rdy);
    chk("mul_lat", lat, 35);
    chk("mul_starts", starts, 1);
    chk("mul_hi", rsp_hi, 1);
    chk("mul_lo", rsp_lo, 0);
    take_rsp();

    // DIV with consumer stalling 10 cycles
    run_op(32'd100, 32'd7, 2'b11, lat, starts, rdy);
    chk("div_lat", lat, 35);
    chk("div_lo", rsp_lo, 14);
    chk("div_hi", rsp_hi, 2);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_lo != 14 || rsp_hi != 2 || au_a != 100 || au_b != 7 ||
          au_aluop != 2'b11 || au_start || req_ready) bad++;
    end
    chk("div_hold", bad, 0);
    take_rsp();
    chk("div_valid_drop", rsp_valid, 0);

    // DIV by zero
    run_op(32'd1, 32'd0, 2'b11, lat, starts, rdy);
`ifdef AU_DIV0_TRAP_EN
    chk("div0_lat", lat, 1);
    chk("div0_starts", starts, 0);
    chk("div0_err", rsp_err, 1);
    chk("div0_s", rsp_s, 0);
    chk("div0_hi", rsp_hi, 0);
    chk("div0_lo", rsp_lo, 0);
    chk("div0_zero", rsp_zero, 1);
`else
    chk("div0_lat", lat, 35);
    chk("div0_starts", starts, 1);
    chk("div0_err", rsp_err, 0);
    chk("div0_lo", rsp_lo, 32'hFFFF_FFFF);
    chk("div0_hi", rsp_hi, 1);
`endif
    take_rsp();

    // Reset in the middle of a MULT
    req_a = 32'd3;
    req_b = 32'd4;
    req_op = 2'b10;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_au_start", au_start, 0);
    chk("mrst_req_ready", req_ready, 1);
    chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_au_a", au_a, 0);
    chk("mrst_au_aluop", au_aluop, 0);
    chk("mrst_rsp_lo", rsp_lo, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("mrst_no_rsp", seen, 0);
    chk("mrst_idle_ready", req_ready, 1);

    // Wraparound ADD after reset recovery
    run_op(32'hFFFF_FFFF, 32'd1, 2'b00, lat, starts, rdy);
    chk("wrap_lat", lat, 3);
    chk("wrap_s", rsp_s, 0);
    chk("wrap_zero", rsp_zero, 1);
    take_rsp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
